// File: rtl/bcd_disp_pkg.sv
// Shared constants for the multiplexed BCD display scanner: active-high glyphs
// (bit0=a .. bit6=g) and the blink period used when BCD_DISP_BLINK_EN is defined.
package bcd_disp_pkg;

   localparam logic [6:0] GLYPH_0     = 7'h3F;
   localparam logic [6:0] GLYPH_1     = 7'h06;
   localparam logic [6:0] GLYPH_2     = 7'h5B;
   localparam logic [6:0] GLYPH_3     = 7'h4F;
   localparam logic [6:0] GLYPH_4     = 7'h66;
   localparam logic [6:0] GLYPH_5     = 7'h6D;
   localparam logic [6:0] GLYPH_6     = 7'h7D;
   localparam logic [6:0] GLYPH_7     = 7'h07;
   localparam logic [6:0] GLYPH_8     = 7'h7F;
   localparam logic [6:0] GLYPH_9     = 7'h6F;
   localparam logic [6:0] GLYPH_DASH  = 7'h40;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

   localparam int BLINK_PERIOD = 32;
   localparam int BLINK_CNT_W  = $clog2(BLINK_PERIOD);

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Control/display bundle between the BCD arithmetic blocks and the scanner.
// Carries the blink request only when BCD_DISP_BLINK_EN is defined.
interface bcd_display_scanner_if #(
   parameter int DIGITS = 5
) ();

   logic                  load;
   logic [4*DIGITS-1:0]   bcd_in;
   logic                  blank_en;
`ifdef BCD_DISP_BLINK_EN
   logic                  blink;
`endif
   logic [6:0]            segments;
   logic [DIGITS-1:0]     anodes;
   logic                  frame_done;

`ifdef BCD_DISP_BLINK_EN
   modport master (output load, bcd_in, blank_en, blink,
                   input  segments, anodes, frame_done);
   modport slave  (input  load, bcd_in, blank_en, blink,
                   output segments, anodes, frame_done);
`else
   modport master (output load, bcd_in, blank_en,
                   input  segments, anodes, frame_done);
   modport slave  (input  load, bcd_in, blank_en,
                   output segments, anodes, frame_done);
`endif

endinterface

// File: rtl/seg7_glyph.sv
// Combinational BCD to 7-segment decode, active-high; values 10-15 show a dash.
module seg7_glyph
   import bcd_disp_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] glyph
);

   always_comb begin
      glyph = GLYPH_DASH;
      if (blank) begin
         glyph = GLYPH_BLANK;
      end else begin
         case (digit)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = GLYPH_DASH;
         endcase
      end
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed N-digit 7-segment driver with leading-zero blanking and frame pulse.
// Define BCD_DISP_BLINK_EN to add the 32-frame blink of the anodes.
module bcd_display_scanner
   import bcd_disp_pkg::*;
#(
   parameter int DIGITS         = 5,
   parameter int CLK_DIV        = 100000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset,
   bcd_display_scanner_if.slave  bus
);

   localparam int                CNT_W    = $clog2(CLK_DIV);
   localparam int                IDX_W    = $clog2(DIGITS);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};
   localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [4*DIGITS-1:0] latch_q, latch_d;
   logic [6:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   an_q, an_d;
   logic                frame_done_q, frame_done_d;

   logic                tick;
   logic [3:0]          cur_digit;
   logic                cur_blank;
   logic                zeros_above;
   logic [6:0]          glyph;
   logic [DIGITS-1:0]   an_sel;

   always_comb begin
      tick         = (cnt_q == CNT_LAST);
      cnt_d        = tick ? '0 : cnt_q + 1'b1;
      idx_d        = idx_q;
      if (tick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      latch_d      = bus.load ? bus.bcd_in : latch_q;
      frame_done_d = tick && (idx_q == IDX_LAST);
   end

   // Walk from the most significant digit down so zeros_above covers DIGITS-1..i.
   always_comb begin
      cur_digit   = 4'd0;
      cur_blank   = 1'b0;
      zeros_above = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zeros_above = zeros_above && (latch_q[4*i +: 4] == 4'd0);
         if (idx_q == IDX_W'(i)) begin
            cur_digit = latch_q[4*i +: 4];
            cur_blank = bus.blank_en && zeros_above && (i != 0);
         end
      end
   end

   seg7_glyph u_glyph (
      .digit (cur_digit),
      .blank (cur_blank),
      .glyph (glyph)
   );

`ifdef BCD_DISP_BLINK_EN
   logic [BLINK_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = frame_done_d ? frame_cnt_q + 1'b1 : frame_cnt_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end
`endif

   always_comb begin
      for (int i = 0; i < DIGITS; i++) begin
         an_sel[i] = (idx_q == IDX_W'(i));
      end
      seg_d = SEG_ACTIVE_LOW ? ~glyph : glyph;
      an_d  = AN_ACTIVE_LOW ? ~an_sel : an_sel;
`ifdef BCD_DISP_BLINK_EN
      // Upper half of the blink period darkens the display; scanning keeps going.
      if (bus.blink && frame_cnt_q[BLINK_CNT_W-1]) begin
         an_d = AN_OFF;
      end
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         latch_q      <= '0;
         seg_q        <= SEG_OFF;
         an_q         <= AN_OFF;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         latch_q      <= latch_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.segments   = seg_q;
   assign bus.anodes     = an_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner (DIGITS=5, CLK_DIV=4, active-low outputs).
// With BCD_DISP_BLINK_EN defined it also exercises the blink window.
module tb_bcd_display_scanner;

   localparam int         DIGITS  = 5;
   localparam int         FRAME   = 20;
   localparam logic [4:0] AN_OFF  = 5'h1F;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   typedef struct packed {
      logic [4:0] an;
      logic [6:0] seg;
      logic       fd;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   errors   = 0;
   int   edge_cnt = 0;
   bit   blink_mode = 1'b0;
   exp_t exp_q[$];

   bcd_display_scanner_if #(.DIGITS(DIGITS)) bus ();

   bcd_display_scanner #(
      .DIGITS         (DIGITS),
      .CLK_DIV        (4),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clock (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) edge_cnt <= 0;
      else       edge_cnt <= edge_cnt + 1;
   end

   task automatic push_one(input int d, input logic [6:0] seg, input logic fd);
      exp_t e;
      e.an  = ~(5'b00001 << d);
      e.seg = seg;
      e.fd  = fd;
      exp_q.push_back(e);
   endtask

   // segs packed {d4,d3,d2,d1,d0}; fd0 = frame_done seen just before digit 0
   task automatic push_frame(input logic [34:0] segs, input logic fd0);
      for (int d = 0; d < DIGITS; d++) begin
         push_one(d, segs[7*d +: 7], (d == 0) ? fd0 : 1'b0);
      end
   endtask

   // Present load so that it is sampled on edge e; blank_en changes right after e.
   task automatic load_at(input int e, input logic [19:0] v, input logic blk);
      while (edge_cnt < e - 1) @(negedge clk);
      bus.load   = 1'b1;
      bus.bcd_in = v;
      @(negedge clk);
      bus.load     = 1'b0;
      bus.blank_en = blk;
   endtask

   // Monitor: every anode change is one displayed digit and must match the queue head.
   initial begin : monitor
      logic [4:0] prev_an;
      logic [6:0] prev_seg;
      logic       fd_last;
      int         fd_cnt;
      exp_t       e;
      prev_an  = AN_OFF;
      prev_seg = SEG_OFF;
      fd_last  = 1'b0;
      fd_cnt   = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            checks++;
            if (bus.anodes !== AN_OFF || bus.segments !== SEG_OFF || bus.frame_done !== 1'b0) begin
               errors++;
               $display("FAIL reset_state: got an=%h seg=%h fd=%b, want an=%h seg=%h fd=0",
                        bus.anodes, bus.segments, bus.frame_done, AN_OFF, SEG_OFF);
            end
            fd_cnt  = 0;
            fd_last = 1'b0;
         end else begin
            fd_cnt++;
            if (bus.frame_done === 1'b1) begin
               checks++;
               if (fd_cnt != FRAME) begin
                  errors++;
                  $display("FAIL frame_period: got %0d cycles, want %0d", fd_cnt, FRAME);
               end
               fd_cnt = 0;
            end
            if (!blink_mode) begin
               if (bus.anodes !== prev_an) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_digit: got an=%h seg=%h, want no further digit",
                              bus.anodes, bus.segments);
                  end else begin
                     e = exp_q.pop_front();
                     if (bus.anodes !== e.an || bus.segments !== e.seg || fd_last !== e.fd) begin
                        errors++;
                        $display("FAIL digit_glyph: got an=%h seg=%h fd_prev=%b, want an=%h seg=%h fd_prev=%b",
                                 bus.anodes, bus.segments, fd_last, e.an, e.seg, e.fd);
                     end
                  end
               end else if (bus.segments !== prev_seg) begin
                  checks++;
                  errors++;
                  $display("FAIL mid_dwell_change: got seg=%h on an=%h, want seg=%h held",
                           bus.segments, bus.anodes, prev_seg);
               end
            end
            fd_last = bus.frame_done;
         end
         prev_an  = bus.anodes;
         prev_seg = bus.segments;
      end
   end

   initial begin : watchdog
      #50000;
      errors++;
      $display("FAIL watchdog: got no finish by t=%0t, want finish earlier", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : stimulus
      bus.load     = 1'b0;
      bus.bcd_in   = '0;
      bus.blank_en = 1'b0;
`ifdef BCD_DISP_BLINK_EN
      bus.blink    = 1'b0;
`endif
      // frame 0: zero latch, no blanking
      push_frame({7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);
      // frames 1,2: 0x12345
      push_frame({7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, 1'b1);
      push_frame({7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, 1'b1);
      // frame 3: 0x00070 blanked
      push_frame({7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h40}, 1'b1);
      // frame 4: 0x00000 blanked
      push_frame({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b1);
      // frame 5: 0x0A0F3 unblanked
      push_frame({7'h40, 7'h3F, 7'h40, 7'h3F, 7'h30}, 1'b1);
      // frame 6: 0x0A0F3 blanked for d0,d1, then 0x98765 loaded on the d1->d2 tick
      push_frame({7'h10, 7'h00, 7'h78, 7'h3F, 7'h30}, 1'b1);
      // frame 7: 0x98765 until reset during digit 3
      push_one(0, 7'h12, 1'b1);
      push_one(1, 7'h02, 1'b0);
      push_one(2, 7'h78, 1'b0);
      push_one(3, 7'h00, 1'b0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 reset = 1'b0;

      load_at(20,  20'h12345, 1'b0);
      load_at(60,  20'h00070, 1'b1);
      load_at(80,  20'h00000, 1'b1);
      load_at(100, 20'h0A0F3, 1'b0);
      load_at(120, 20'h0A0F3, 1'b1);
      load_at(128, 20'h98765, 1'b0);

      while (edge_cnt < 154) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;

      // after release: zero latch again, first frame_done one full frame later
      push_frame({7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0);
      push_one(0, 7'h40, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 reset = 1'b0;

      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_digits: got %0d still queued, want 0", exp_q.size());
      end

`ifdef BCD_DISP_BLINK_EN
      blink_mode = 1'b1;
      bus.blink  = 1'b1;
      for (int f = 2; f < 36; f++) begin
         logic [4:0] want;
         while (edge_cnt < FRAME * f + 10) @(negedge clk);
         want = ((f % 32) >= 16) ? AN_OFF : 5'h1B;
         checks++;
         if (bus.anodes !== want) begin
            errors++;
            $display("FAIL blink_anodes: frame %0d got an=%h, want an=%h", f, bus.anodes, want);
         end
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
